// File: rtl/fft8_seq_core.sv
// fft8_seq_core: sequential 8-point radix-2 DIT FFT, one butterfly per cycle.
//
// Eight real samples are loaded, one per handshake, into an 8-entry complex
// register file in bit-reversed order. Twelve butterflies (3 stages x 4) then
// run in place, one per clock. The 8 complex bins are streamed out in natural
// order. No scaling is applied between stages.
//
// Ports:
//   clk, rst_n       clock, synchronous active-low reset
//   ena              global enable; 0 freezes all state and handshakes
//   in_data/valid/ready    real sample input stream (signed IN_W)
//   out_re/im/idx/valid/last/ready   complex bin output stream (signed ACC_W)
//   busy             high while butterflies are being computed
//
// ACC_W must be at least IN_W+4: 8 samples gain up to 3 bits through the
// three stages, plus one bit of headroom for the twiddle sums.

// W^t * x for t in 0..3 (W = e^(-j*2*pi/8)), 1/sqrt(2) as a Q8 constant.
// Result is one bit wider than the input so the sums feeding the top-level
// adders never wrap.
module fft8_twiddle #(
  parameter int ACC_W = 12,
  parameter int TW_C  = 181
) (
  input  logic [1:0]              tw,
  input  logic signed [ACC_W-1:0] x_re,
  input  logic signed [ACC_W-1:0] x_im,
  output logic signed [ACC_W:0]   y_re,
  output logic signed [ACC_W:0]   y_im
);
  localparam int SW = ACC_W + 1;
  localparam int PW = SW + 10;
  localparam logic signed [9:0] TWS = 10'(TW_C);

  logic signed [SW-1:0] re_e, im_e;
  logic signed [SW-1:0] s_pos, s_dif, s_neg;
  logic signed [PW-1:0] p_pos, p_dif, p_neg;

  assign re_e  = SW'(x_re);
  assign im_e  = SW'(x_im);
  assign s_pos = re_e + im_e;
  assign s_dif = im_e - re_e;
  assign s_neg = -re_e - im_e;

  assign p_pos = PW'(s_pos) * PW'(TWS);
  assign p_dif = PW'(s_dif) * PW'(TWS);
  assign p_neg = PW'(s_neg) * PW'(TWS);

  // >>> on the signed product gives floor rounding of the Q8 scale.
  always_comb begin
    y_re = re_e;
    y_im = im_e;
    case (tw)
      2'd1: begin
        y_re = SW'(p_pos >>> 8);
        y_im = SW'(p_dif >>> 8);
      end
      2'd2: begin
        y_re = im_e;
        y_im = -re_e;
      end
      2'd3: begin
        y_re = SW'(p_dif >>> 8);
        y_im = SW'(p_neg >>> 8);
      end
      default: ;
    endcase
  end
endmodule

module fft8_seq_core #(
  parameter int IN_W  = 8,
  parameter int ACC_W = 12,
  parameter int TW_C  = 181
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    ena,
  input  logic signed [IN_W-1:0]  in_data,
  input  logic                    in_valid,
  output logic                    in_ready,
  output logic signed [ACC_W-1:0] out_re,
  output logic signed [ACC_W-1:0] out_im,
  output logic [2:0]              out_idx,
  output logic                    out_valid,
  output logic                    out_last,
  input  logic                    out_ready,
  output logic                    busy
);
  localparam int SW = ACC_W + 1;

  typedef enum logic [1:0] {LOAD, COMPUTE, OUTPUT} state_t;

  typedef struct packed {
    logic signed [ACC_W-1:0] re;
    logic signed [ACC_W-1:0] im;
  } cplx_t;

  state_t     state, state_nxt;
  logic [2:0] ld_cnt, out_k;
  logic [1:0] stg, bfly;
  logic       in_fire, out_fire, bfly_last;

  cplx_t [7:0] rf;
  logic [2:0]  idx_i, idx_j, ld_addr;
  logic [1:0]  tw;
  cplx_t       xi, xj, new_i, new_j;
  logic signed [SW-1:0] y_re, y_im, xi_re_e, xi_im_e;

  function automatic logic [2:0] bitrev3(input logic [2:0] n);
    return {n[0], n[1], n[2]};
  endfunction

  // Transfers only happen on enabled edges, even if valid/ready are both high.
  assign in_fire   = ena & in_valid & (state == LOAD);
  assign out_fire  = ena & out_ready & (state == OUTPUT);
  assign bfly_last = (stg == 2'd2) && (bfly == 2'd3);

  // ---------------- FSM ----------------
  always_ff @(posedge clk) begin
    if (!rst_n)   state <= LOAD;
    else if (ena) state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    case (state)
      LOAD: begin
        in_ready = 1'b1;
        if (in_fire && ld_cnt == 3'd7) state_nxt = COMPUTE;
      end
      COMPUTE: begin
        busy = 1'b1;
        if (bfly_last) state_nxt = OUTPUT;
      end
      OUTPUT: begin
        out_valid = 1'b1;
        if (out_fire && out_k == 3'd7) state_nxt = LOAD;
      end
      default: state_nxt = LOAD;
    endcase
  end

  // ---------------- counters ----------------
  // 3-bit counters wrap to 0 after 7, so the load and output counters are
  // already cleared when a frame completes.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ld_cnt <= '0;
      stg    <= '0;
      bfly   <= '0;
      out_k  <= '0;
    end else if (ena) begin
      if (in_fire) ld_cnt <= ld_cnt + 3'd1;
      if (state == COMPUTE) begin
        bfly <= bfly + 2'd1;
        if (bfly == 2'd3) stg <= (stg == 2'd2) ? 2'd0 : stg + 2'd1;
      end
      if (out_fire) out_k <= out_k + 3'd1;
    end
  end

  // ---------------- butterfly addressing ----------------
  // Stage s pairs entries half=2^s apart; twiddle step is 4>>s.
  always_comb begin
    idx_i = {bfly, 1'b0};
    idx_j = {bfly, 1'b1};
    tw    = 2'd0;
    case (stg)
      2'd1: begin
        idx_i = {bfly[1], 1'b0, bfly[0]};
        idx_j = {bfly[1], 1'b1, bfly[0]};
        tw    = {bfly[0], 1'b0};
      end
      2'd2: begin
        idx_i = {1'b0, bfly};
        idx_j = {1'b1, bfly};
        tw    = bfly;
      end
      default: ;
    endcase
  end

  assign xi = rf[idx_i];
  assign xj = rf[idx_j];

  fft8_twiddle #(.ACC_W(ACC_W), .TW_C(TW_C)) u_tw (
    .tw   (tw),
    .x_re (xj.re),
    .x_im (xj.im),
    .y_re (y_re),
    .y_im (y_im)
  );

  assign xi_re_e = SW'(xi.re);
  assign xi_im_e = SW'(xi.im);

  always_comb begin
    new_i.re = ACC_W'(xi_re_e + y_re);
    new_i.im = ACC_W'(xi_im_e + y_im);
    new_j.re = ACC_W'(xi_re_e - y_re);
    new_j.im = ACC_W'(xi_im_e - y_im);
  end

  // ---------------- register file ----------------
  // Contents are don't-care after reset; a new frame overwrites every entry.
  assign ld_addr = bitrev3(ld_cnt);

  always_ff @(posedge clk) begin
    if (in_fire) begin
      rf[ld_addr].re <= ACC_W'(in_data);
      rf[ld_addr].im <= '0;
    end else if (ena && state == COMPUTE) begin
      rf[idx_i] <= new_i;
      rf[idx_j] <= new_j;
    end
  end

  // ---------------- output stage ----------------
  // Data is forced to zero outside OUTPUT so stale entries are never visible.
  assign out_idx  = out_k;
  assign out_last = out_valid & (out_k == 3'd7);
  assign out_re   = out_valid ? rf[out_k].re : '0;
  assign out_im   = out_valid ? rf[out_k].im : '0;

endmodule

// File: doc/fft8_seq_core.md
# fft8_seq_core

Sequential 8-point radix-2 decimation-in-time FFT engine with valid/ready streaming on both sides.
- Upstream: the sample framer delivers 8 real signed samples, one per handshake.
- Downstream: the magnitude/output stage receives the 8 complex bins in natural order.
- One butterfly is computed per cycle from a single 8-entry complex register file, which replaces the wide combinational FFT with a small datapath.

## Interface
Parameters:
- IN_W, 8, input sample width (signed, two's complement)
- ACC_W, 12, internal and output real/imag width (signed); must be ≥ IN_W+4
- TW_C, 181, Q8 constant for 1/√2 (181/256)

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, synchronous, active-low
- ena  in  1  global enable; when 0 all state, counters and outputs hold
- in_data  in  IN_W  real sample, signed; imaginary part is implicitly 0
- in_valid  in  1  sample present
- in_ready  out  1  core accepts a sample this cycle
- out_re  out  ACC_W  bin real part, signed
- out_im  out  ACC_W  bin imag part, signed
- out_idx  out  3  bin index k, 0..7
- out_valid  out  1  bin present
- out_last  out  1  high with bin 7
- out_ready  in  1  downstream accepts the bin
- busy  out  1  high in COMPUTE

## Operation
- FSM states:
  - LOAD (reset state).
  - COMPUTE.
  - OUTPUT.
- LOAD:
  - in_ready=1.
  - Each accepted sample n (load counter 0..7) is sign-extended to ACC_W and written to entry bitrev3(n); imag is set to 0.
  - The edge that accepts sample 7 moves the FSM to COMPUTE.
- COMPUTE: stage s=0..2, butterfly b=0..3, 12 cycles total, s-major order.
  - half = 2^s.
  - top index i = (b / half)·2·half + (b mod half); bottom index j = i + half.
  - Twiddle t = (b mod half)·(4 >> s).
  - Computed y = W^t·x[j]:
    - t=0: y = (re, im).
    - t=1: y = (((re+im)·TW_C)>>>8, ((im−re)·TW_C)>>>8).
    - t=2: y = (im, −re).
    - t=3: y = (((im−re)·TW_C)>>>8, ((−re−im)·TW_C)>>>8).
  - >>> is an arithmetic shift (floor). Sums are formed at ACC_W+1 bits before the multiply.
  - Write x[i] ← x[i]+y and x[j] ← x[i]−y on the same edge, truncated to ACC_W (no overflow is possible for IN_W=8).
- OUTPUT:
  - Presents entry k on out_re/out_im with out_idx=k, k=0..7, natural order.
  - k advances on out_valid & out_ready.
  - The handshake of k=7 returns the FSM to LOAD, clears the load counter and re-enables in_ready.
- No scaling is applied between stages. Bin k equals the floor-rounded DFT Σ x[n]·e^(−j2πkn/8).

## Timing
- Reset (rst_n=0 at an edge, regardless of ena):
  - state=LOAD, all counters 0.
  - in_ready=1 after the edge.
  - out_valid=0, out_last=0, busy=0, out_idx=0, out_re=0, out_im=0.
  - Register-file contents are don't-care.
- Reset mid-LOAD, mid-COMPUTE or mid-OUTPUT aborts the frame. Partial data is never emitted.
- in_ready and out_valid are never high in the same cycle. in_valid is ignored outside LOAD.
- Latency: the edge E that accepts sample 7 enters COMPUTE. Edges E+1..E+12 perform the 12 butterflies. out_valid is high from E+12 onward.
- With out_ready=1 continuously, bins stream one per cycle. The 8th handshake occurs at E+20, and in_ready=1 after it.
- With out_ready=0, out_valid, out_re, out_im, out_idx and out_last hold stable.
- ena=0 stalls everything, including a pending handshake: no transfer occurs in either direction while ena=0, even if the valid/ready pair is high.
- busy is high for exactly the 12 COMPUTE cycles.

## Test plan
- Impulse: samples 1,0,0,0,0,0,0,0 -> all 8 bins (re,im)=(1,0); out_last only on idx 7; out_valid rises exactly 12 edges after the 8th accept.
- DC full scale: all samples −128 -> bin0=(−1024,0), bins 1..7=(0,0); no wrap.
- Nyquist: +64,−64 alternating -> bin4=(512,0), all others (0,0).
- Twiddle rounding: samples 0,100,0,0,0,0,0,0 -> bin1=(70,−71), bin2=(0,−100), bin3=(−71,−71), bin4=(−100,0); the bench model uses the exact >>> floor rule.
- Backpressure and ena:
  - out_ready toggles 1,0,0,1,... -> no bin is lost or duplicated, and outputs are stable while stalled.
  - ena=0 for 5 cycles mid-COMPUTE -> latency grows by exactly 5.
- Reset mid-frame:
  - rst_n low during COMPUTE -> out_valid=0 and in_ready=1 after the edge.
  - A following frame of impulse data -> all bins (1,0).
